// File: rtl/sdram_pkg.sv
// Shared command encodings, FSM state type and helpers for the SDRAM
// mode-register programming sequencer.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_WAIT_TRP,
    ST_LOAD_MODE,
    ST_WAIT_TMRD,
    ST_DONE
  } mr_state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int unsigned lowest_set_idx(input logic [31:0] mask);
    int unsigned idx;
    logic [31:0] sh;
    idx = 0;
    for (int unsigned i = 32; i > 0; i--) begin
      sh = mask >> (i - 1);
      if (sh[0]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// Load/decrement delay counter with zero flag; saturates at zero.
module sdram_wait_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_mode_reg_seq.sv
// Mode-register programming sequencer: optional PRECHARGE + tRP, then one
// LOAD_MODE (+ tMRD) per selected register in ascending index order.
module sdram_mode_reg_seq
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned BA_W     = 2,
  parameter int unsigned NUM_MR   = 2,
  parameter int unsigned TRP_CYC  = 2,
  parameter int unsigned TMRD_CYC = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     sdram_init,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NUM_MR-1:0]        req_mask,
  input  logic                     req_skip_pre,
  input  logic [NUM_MR*ADDR_W-1:0] mr_val,
  input  logic [NUM_MR*BA_W-1:0]   mr_ba,
  output logic [3:0]               sdram_cmd,
  output logic [BA_W-1:0]          sdram_ba,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned MAXW  = (TRP_CYC > TMRD_CYC) ? TRP_CYC : TMRD_CYC;
  localparam int unsigned CNT_W = (MAXW == 0) ? 1 : $clog2(MAXW + 1);
  localparam logic [CNT_W-1:0] TRP_LD  = (TRP_CYC  > 0) ? CNT_W'(TRP_CYC  - 1) : '0;
  localparam logic [CNT_W-1:0] TMRD_LD = (TMRD_CYC > 0) ? CNT_W'(TMRD_CYC - 1) : '0;

  mr_state_t                 state_q, state_d;
  logic [3:0]                cmd_q;
  logic [BA_W-1:0]           ba_q;
  logic [ADDR_W-1:0]         addr_q;
  logic                      done_q;
  logic [NUM_MR-1:0]         pend_q;
  logic [NUM_MR*ADDR_W-1:0]  val_q;
  logic [NUM_MR*BA_W-1:0]    bank_q;

  logic                      accept;
  logic [NUM_MR-1:0]         src_mask;
  logic [NUM_MR*ADDR_W-1:0]  src_val;
  logic [NUM_MR*BA_W-1:0]    src_ba;
  int unsigned               iss_idx;
  logic [NUM_MR-1:0]         iss_onehot;
  logic [NUM_MR-1:0]         pend_d;
  logic [ADDR_W-1:0]         addr_acc [NUM_MR+1];
  logic [BA_W-1:0]           ba_acc   [NUM_MR+1];

  logic                      cnt_load;
  logic [CNT_W-1:0]          cnt_val;
  logic                      cnt_dec;
  logic                      cnt_zero;

  assign req_ready = (state_q == ST_IDLE) && sdram_init;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_valid && req_ready;

  assign sdram_cmd  = cmd_q;
  assign sdram_ba   = ba_q;
  assign sdram_addr = addr_q;
  assign done       = done_q;

  // A skip-precharge request issues its first LOAD_MODE straight from the
  // live inputs, since the capture registers load on that same edge.
  assign src_mask = (state_q == ST_IDLE) ? req_mask : pend_q;
  assign src_val  = (state_q == ST_IDLE) ? mr_val   : val_q;
  assign src_ba   = (state_q == ST_IDLE) ? mr_ba    : bank_q;
  assign iss_idx  = lowest_set_idx(32'(src_mask));

  assign addr_acc[0] = '0;
  assign ba_acc[0]   = '0;
  for (genvar g = 0; g < NUM_MR; g++) begin : g_sel
    assign iss_onehot[g] = (iss_idx == g) && src_mask[g];
    assign addr_acc[g+1] = addr_acc[g] | (iss_onehot[g] ? src_val[g*ADDR_W +: ADDR_W] : '0);
    assign ba_acc[g+1]   = ba_acc[g]   | (iss_onehot[g] ? src_ba[g*BA_W +: BA_W]       : '0);
  end

  assign pend_d = src_mask & ~iss_onehot;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_mask == '0)    state_d = ST_DONE;
          else if (req_skip_pre) state_d = ST_LOAD_MODE;
          else                   state_d = ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: state_d = (TRP_CYC == 0) ? ST_LOAD_MODE : ST_WAIT_TRP;
      ST_WAIT_TRP:  if (cnt_zero) state_d = ST_LOAD_MODE;
      ST_LOAD_MODE: begin
        if (TMRD_CYC != 0)     state_d = ST_WAIT_TMRD;
        else if (pend_q != '0) state_d = ST_LOAD_MODE;
        else                   state_d = ST_DONE;
      end
      ST_WAIT_TMRD: if (cnt_zero) state_d = (pend_q != '0) ? ST_LOAD_MODE : ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = (state_q == ST_WAIT_TRP) || (state_q == ST_WAIT_TMRD);
    if ((state_q == ST_PRECHARGE) && (TRP_CYC != 0)) begin
      cnt_load = 1'b1;
      cnt_val  = TRP_LD;
    end
    if ((state_q == ST_LOAD_MODE) && (TMRD_CYC != 0)) begin
      cnt_load = 1'b1;
      cnt_val  = TMRD_LD;
    end
  end

  sdram_wait_cnt #(
    .W (CNT_W)
  ) u_wait_cnt (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Outputs are registered from the next state so each command sits in the
  // same cycle as the state that issues it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      ba_q    <= '1;
      addr_q  <= '1;
      done_q  <= 1'b0;
      pend_q  <= '0;
      val_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= CMD_NOP;
      ba_q    <= '1;
      addr_q  <= '1;
      done_q  <= (state_d == ST_DONE);
      if (accept) begin
        val_q  <= mr_val;
        bank_q <= mr_ba;
        pend_q <= req_mask;
      end
      if (state_d == ST_PRECHARGE) begin
        cmd_q <= CMD_PRECHARGE;
      end else if (state_d == ST_LOAD_MODE) begin
        cmd_q  <= CMD_LOAD_MODE;
        ba_q   <= ba_acc[NUM_MR];
        addr_q <= addr_acc[NUM_MR];
        pend_q <= pend_d;
      end
    end
  end

endmodule
